// File: rtl/unpack_pkg.sv
// Shared types and helpers for the packed word unpacker.
package unpack_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam int OUT_W = 32;

    // Index width never collapses to zero bits, even for a single-field word.
    function automatic int idx_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/unpack_zero_scan.sv
// Combinational suffix-OR over packed fields: nz_from[k] is set when any field
// at position k or above is nonzero. Used only by the zero-skipping build.
module unpack_zero_scan #(
    parameter int FIELD_W    = 1,
    parameter int NUM_FIELDS = 6
) (
    input  logic [NUM_FIELDS*FIELD_W-1:0] fields,
    output logic [NUM_FIELDS-1:0]         nz_from
);

    logic acc;

    always_comb begin
        nz_from = '0;
        acc     = 1'b0;
        for (int k = NUM_FIELDS - 1; k >= 0; k--) begin
            acc        = acc | (|fields[k*FIELD_W +: FIELD_W]);
            nz_from[k] = acc;
        end
    end

endmodule

// File: rtl/packed_word_unpacker.sv
// Splits one packed word into NUM_FIELDS equal fields, emitted LSB field first.
// Defining UNPACK_SKIP_ZERO_EN suppresses zero-valued fields.
module packed_word_unpacker
    import unpack_pkg::*;
#(
    parameter int  WIDTH      = 32,
    parameter int  FIELD_W    = 1,
    parameter int  NUM_FIELDS = 6,
    localparam int IDX_W      = idx_width(NUM_FIELDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_field,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             word_done
);

    localparam int USED_W = NUM_FIELDS * FIELD_W;

    if (FIELD_W < 1 || FIELD_W > OUT_W) begin : g_bad_field_w
        $error("FIELD_W must lie in 1..32");
    end
    if (USED_W > WIDTH) begin : g_bad_width
        $error("NUM_FIELDS*FIELD_W exceeds WIDTH");
    end

    state_t              state, state_nxt;
    logic [USED_W-1:0]   shreg, shreg_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic                done_nxt;
    logic [FIELD_W-1:0]  cur_field;
    logic                is_last;
    logic                field_vis;
    logic                word_empty;

    // Bits above the used region are deliberately dropped on capture.
    logic unused_hi_bits;
    assign unused_hi_bits = ^in_word;

    assign cur_field = shreg[FIELD_W-1:0];

`ifdef UNPACK_SKIP_ZERO_EN
    logic [NUM_FIELDS-1:0] nz_from;

    unpack_zero_scan #(
        .FIELD_W   (FIELD_W),
        .NUM_FIELDS(NUM_FIELDS)
    ) u_zero_scan (
        .fields (shreg),
        .nz_from(nz_from)
    );

    assign word_empty = !nz_from[0];
    assign field_vis  = |cur_field;
    if (NUM_FIELDS == 1) begin : g_one_field
        assign is_last = 1'b1;
    end else begin : g_many_fields
        assign is_last = !nz_from[1];
    end
`else
    assign word_empty = 1'b0;
    assign field_vis  = 1'b1;
    assign is_last    = (idx == IDX_W'(NUM_FIELDS - 1));
`endif

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        idx_nxt   = idx;
        done_nxt  = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shreg_nxt = in_word[USED_W-1:0];
                    idx_nxt   = '0;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (word_empty) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                    done_nxt  = 1'b1;
                end else if (!field_vis) begin
                    shreg_nxt = shreg >> FIELD_W;
                    idx_nxt   = idx + IDX_W'(1);
                end else begin
                    out_valid = 1'b1;
                    if (out_ready) begin
                        shreg_nxt = shreg >> FIELD_W;
                        idx_nxt   = idx + IDX_W'(1);
                        if (is_last) begin
                            state_nxt = IDLE;
                            idx_nxt   = '0;
                            done_nxt  = 1'b1;
                        end
                    end
                end
            end
        endcase
        // Handshakes are refused while reset is held so nothing is lost to it.
        if (rst) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
        end
    end

    assign out_field = OUT_W'(cur_field);
    assign out_idx   = idx;
    assign out_last  = out_valid && is_last;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            idx       <= '0;
            word_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            idx       <= idx_nxt;
            word_done <= done_nxt;
        end
    end

endmodule
